apb_arbiter: RTL and testbench
==============================

APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, max ACCESS-state cycles waiting for m_pready before forced error termination (1..65535).
REQ-002 Parameter RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
REQ-003 pclk  in  1  sole clock, all logic on rising edge.
REQ-004 presetn  in  1  reset, synchronous, active-low.
REQ-005 s0_psel, s0_penable, s0_pwrite / s1_*  in  1 each  requester 0/1 APB control (block is APB slave to each).
REQ-006 s0_paddr, s0_pwdata / s1_*  in  32 each  requester address, write data.
REQ-007 s0_pstrb / s1_pstrb  in  4; s0_pprot / s1_pprot  in  3  requester strobe, protection.
REQ-008 s0_pready, s0_pslverr / s1_*  out  1 each; s0_prdata / s1_prdata  out  32  responses per requester.
REQ-009 m_psel, m_penable, m_pwrite  out  1 each; m_paddr, m_pwdata  out  32; m_pstrb  out  4; m_pprot  out  3  shared downstream APB master port.
REQ-010 m_pready, m_pslverr  in  1 each; m_prdata  in  32  downstream slave response.

Function
REQ-011 The FSM SHALL have states IDLE, SETUP, ACCESS; request N = sN_psel.
REQ-012 In IDLE with any request, the arbiter SHALL pick a winner, register its pwrite/paddr/pwdata/pstrb/pprot into a hold register, record grant, and go to SETUP.
REQ-013 Both requesting in IDLE: RR_EN=1 grants the requester not granted last (last_grant resets to 1, so 0 wins first); RR_EN=0 grants 0.
REQ-014 SETUP SHALL drive m_psel=1, m_penable=0 from the hold register, for exactly one cycle, then ACCESS.
REQ-015 ACCESS SHALL drive m_psel=1, m_penable=1; hold-register outputs SHALL stay stable until exit.
REQ-016 ACCESS with m_pready=1: s<grant>_pready=1, s<grant>_prdata=m_prdata, s<grant>_pslverr=m_pslverr combinationally in the same cycle; next state IDLE.
REQ-017 Minimum latency: request sampled in IDLE at cycle T, SETUP at T+1, ACCESS at T+2, s_pready at T+2 earliest; at least one IDLE cycle between downstream transfers.
REQ-018 A 16-bit wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle with m_pready=0; on reaching TIMEOUT_CYC, s<grant>_pready=1, s<grant>_pslverr=1, s<grant>_prdata=0, next state IDLE.
REQ-019 The non-granted requester SHALL see pready=0, pslverr=0, prdata=0 at all times; its request waits, not dropped.
REQ-020 Requester deasserting psel before grant SHALL be ignored; after grant, the downstream transfer SHALL complete and the response is still driven.
REQ-021 Outside SETUP/ACCESS, all m_* outputs SHALL be 0.

Reset
REQ-022 presetn=0 at a clock edge SHALL force IDLE, last_grant=1, wait counter=0, hold register=0; all outputs 0 from that edge, including mid-transfer (transfer abandoned, no response).
REQ-023 First arbitration SHALL occur in the first cycle after presetn returns to 1.

Structure
REQ-024 Package apb_arb_pkg SHALL hold the state enum, the hold-register struct (pwrite, paddr, pwdata, pstrb, pprot) and width constants (ADDR_W=32, DATA_W=32, STRB_W=4, PROT_W=3).
REQ-025 Grant selection SHALL be one sub-module apb_rr_arbiter (2 requests, RR_EN, last_grant in, one-hot grant out).

Verification
REQ-026 s0 write paddr=0x10 pwdata=0xA5A5A5A5, m_pready tied 1 -> m_psel at T+1, m_penable at T+2, m_paddr=0x10, s0_pready=1 at T+2.
REQ-027 s0 and s1 request same cycle, RR_EN=1, three rounds each -> grant order 0,1,0,1,0,1; non-granted pready stays 0.
REQ-028 s1 read, m_pready low 3 cycles then 1 with m_prdata=0xDEADBEEF, m_pslverr=1 -> s1_prdata=0xDEADBEEF, s1_pslverr=1, m_paddr stable throughout.
REQ-029 TIMEOUT_CYC=4, m_pready held 0 -> s0_pready=1, s0_pslverr=1 after 4 ACCESS cycles; FSM in IDLE next cycle.
REQ-030 presetn=0 during ACCESS -> all outputs 0 next edge; after release s0 wins a simultaneous request.

Source files
------------

// File: rtl/apb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// apb_arb_pkg
// Shared types and widths for the two-requester APB arbiter.
//   ADDR_W/DATA_W/STRB_W/PROT_W : APB field widths
//   state_t                     : arbiter FSM state (IDLE, SETUP, ACCESS)
//   hold_t                      : captured request fields driven downstream
// ---------------------------------------------------------------------------
package apb_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int PROT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic              pwrite;
        logic [ADDR_W-1:0] paddr;
        logic [DATA_W-1:0] pwdata;
        logic [STRB_W-1:0] pstrb;
        logic [PROT_W-1:0] pprot;
    } hold_t;

endpackage

// File: rtl/apb_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_arbiter_if
// One APB link. The "master" modport is the side that issues transfers
// (drives psel/penable/pwrite/paddr/pwdata/pstrb/pprot); the "slave"
// modport answers them (drives pready/pslverr/prdata).
//
// Handshake: a transfer is requested while psel=1; the slave completes it
// in the cycle where psel=1, penable=1 and pready=1. pslverr and prdata are
// only meaningful in that completing cycle.
// ---------------------------------------------------------------------------
interface apb_arbiter_if;
    import apb_arb_pkg::*;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [PROT_W-1:0] pprot;
    logic              pready;
    logic              pslverr;
    logic [DATA_W-1:0] prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, pslverr, prdata
    );

endinterface

// File: rtl/apb_arbiter_rr.sv
// ---------------------------------------------------------------------------
// apb_rr_arbiter
// Two-way grant selection, purely combinational.
//   req        : request vector, bit N = requester N
//   last_grant : index of the requester granted most recently
//   grant      : one-hot grant, zero when nothing is requested
// With RR_EN=1 a contested cycle goes to the requester not granted last;
// with RR_EN=0 requester 0 always wins a contest.
// ---------------------------------------------------------------------------
module apb_rr_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (RR_EN && !last_grant) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/apb_arbiter.sv
// ---------------------------------------------------------------------------
// apb_arbiter
// Shares one downstream APB port between two APB requesters.
//   pclk, presetn : clock, synchronous active-low reset
//   s0, s1        : requester links (this block is their APB slave)
//   m             : downstream link (this block is its APB master)
//   dbg_state     : current FSM state
// Parameters:
//   TIMEOUT_CYC   : ACCESS cycles allowed without m.pready before the
//                   transfer is ended with an error response (1..65535)
//   RR_EN         : 1 = round-robin, 0 = fixed priority (requester 0 first)
// The winner's fields are captured in IDLE, so a requester dropping psel
// after the grant does not disturb the downstream transfer.
// ---------------------------------------------------------------------------
module apb_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter bit          RR_EN       = 1'b1
) (
    input  logic          pclk,
    input  logic          presetn,
    apb_arbiter_if.slave  s0,
    apb_arbiter_if.slave  s1,
    apb_arbiter_if.master m,
    output state_t        dbg_state
);

    // The timeout fires in the ACCESS cycle whose entry count is
    // TIMEOUT_CYC-1, i.e. the TIMEOUT_CYC-th ACCESS cycle without pready.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state_q;
    hold_t       hold_q;
    logic        last_grant;
    logic [15:0] wait_cnt;

    logic [1:0]  req;
    logic [1:0]  grant;
    hold_t       s0_fields;
    hold_t       s1_fields;
    hold_t       win_fields;
    logic        in_xfer;
    logic        in_access;
    logic        timeout;
    logic        done;

    assign req = {s1.psel, s0.psel};

    apb_rr_arbiter #(.RR_EN(RR_EN)) u_rr (
        .req       (req),
        .last_grant(last_grant),
        .grant     (grant)
    );

    assign s0_fields  = '{pwrite: s0.pwrite, paddr: s0.paddr, pwdata: s0.pwdata,
                          pstrb: s0.pstrb, pprot: s0.pprot};
    assign s1_fields  = '{pwrite: s1.pwrite, paddr: s1.paddr, pwdata: s1.pwdata,
                          pstrb: s1.pstrb, pprot: s1.pprot};
    assign win_fields = grant[1] ? s1_fields : s0_fields;

    assign in_xfer   = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign in_access = (state_q == ST_ACCESS);
    assign timeout   = in_access && !m.pready && (wait_cnt == WAIT_LAST);
    assign done      = in_access && (m.pready || timeout);

    // last_grant doubles as the index of the transfer in flight.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        hold_q     <= win_fields;
                        last_grant <= grant[1];
                        state_q    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    wait_cnt <= '0;
                    state_q  <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (done) begin
                        state_q <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dbg_state = state_q;

    // Downstream port: everything forced low outside SETUP/ACCESS.
    assign m.psel    = in_xfer;
    assign m.penable = in_access;
    assign m.pwrite  = in_xfer & hold_q.pwrite;
    assign m.paddr   = in_xfer ? hold_q.paddr  : '0;
    assign m.pwdata  = in_xfer ? hold_q.pwdata : '0;
    assign m.pstrb   = in_xfer ? hold_q.pstrb  : '0;
    assign m.pprot   = in_xfer ? hold_q.pprot  : '0;

    // Responses steer to the granted requester only; a timeout reports an
    // error with zero read data.
    assign s0.pready  = done && !last_grant;
    assign s0.pslverr = done && !last_grant && (m.pready ? m.pslverr : 1'b1);
    assign s0.prdata  = (done && !last_grant && m.pready) ? m.prdata : '0;

    assign s1.pready  = done && last_grant;
    assign s1.pslverr = done && last_grant && (m.pready ? m.pslverr : 1'b1);
    assign s1.prdata  = (done && last_grant && m.pready) ? m.prdata : '0;

endmodule

// File: tb/tb_apb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_arbiter
// Directed bench for apb_arbiter (TIMEOUT_CYC=4, RR_EN=1). Inputs change
// 1 time unit after the rising edge; outputs are checked one unit later.
// ---------------------------------------------------------------------------
module tb_apb_arbiter;
    import apb_arb_pkg::*;

    // clock / reset
    logic pclk = 1'b0;
    logic presetn = 1'b0;
    always #5 pclk = ~pclk;

    apb_arbiter_if s0_if ();
    apb_arbiter_if s1_if ();
    apb_arbiter_if m_if ();
    state_t dbg_state;

    apb_arbiter #(.TIMEOUT_CYC(4), .RR_EN(1'b1)) dut (
        .pclk     (pclk),
        .presetn  (presetn),
        .s0       (s0_if),
        .s1       (s1_if),
        .m        (m_if),
        .dbg_state(dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // driver tasks
    task automatic drive_req(input int port, input logic sel, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            s0_if.psel = sel; s0_if.penable = 1'b0; s0_if.pwrite = wr;
            s0_if.paddr = addr; s0_if.pwdata = wdata;
            s0_if.pstrb = 4'hF; s0_if.pprot = 3'b010;
        end else begin
            s1_if.psel = sel; s1_if.penable = 1'b0; s1_if.pwrite = wr;
            s1_if.paddr = addr; s1_if.pwdata = wdata;
            s1_if.pstrb = 4'h3; s1_if.pprot = 3'b001;
        end
    endtask

    task automatic drive_resp(input logic rdy, input logic err, input logic [31:0] rdata);
        m_if.pready = rdy; m_if.pslverr = err; m_if.prdata = rdata;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_m_psel"},    32'(m_if.psel),    32'd0);
        check({tag, "_m_penable"}, 32'(m_if.penable), 32'd0);
        check({tag, "_m_paddr"},   m_if.paddr,        32'd0);
        check({tag, "_s0_pready"}, 32'(s0_if.pready), 32'd0);
        check({tag, "_s1_pready"}, 32'(s1_if.pready), 32'd0);
        check({tag, "_state"},     32'(dbg_state),    32'(ST_IDLE));
    endtask

    task automatic do_reset();
        presetn = 1'b0;
        step();
        step();
        presetn = 1'b1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] exp_addr;
        int          g;

        drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_resp(1'b0, 1'b0, 32'h0);
        #1;
        do_reset();
        settle();
        check_quiet("reset");

        // single s0 write, zero-wait slave
        drive_resp(1'b1, 1'b0, 32'h0);
        drive_req(0, 1'b1, 1'b1, 32'h10, 32'hA5A5_A5A5);
        settle();
        check("t1_T_m_psel", 32'(m_if.psel), 32'd0);
        step();
        check("t1_setup_m_psel",    32'(m_if.psel),    32'd1);
        check("t1_setup_m_penable", 32'(m_if.penable), 32'd0);
        check("t1_setup_m_paddr",   m_if.paddr,        32'h10);
        check("t1_setup_m_pwdata",  m_if.pwdata,       32'hA5A5_A5A5);
        check("t1_setup_m_pwrite",  32'(m_if.pwrite),  32'd1);
        check("t1_setup_m_pstrb",   32'(m_if.pstrb),   32'hF);
        check("t1_setup_m_pprot",   32'(m_if.pprot),   32'h2);
        check("t1_setup_s0_pready", 32'(s0_if.pready), 32'd0);
        s0_if.penable = 1'b1;
        step();
        check("t1_access_m_penable", 32'(m_if.penable), 32'd1);
        check("t1_access_m_paddr",   m_if.paddr,        32'h10);
        check("t1_access_s0_pready", 32'(s0_if.pready), 32'd1);
        check("t1_access_s0_err",    32'(s0_if.pslverr), 32'd0);
        check("t1_access_s1_pready", 32'(s1_if.pready), 32'd0);
        step();
        drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        check_quiet("t1_after");

        // round robin: both hold psel for six back-to-back rounds
        do_reset();
        for (int r = 0; r < 6; r++) exp_q.push_back((r % 2 == 0) ? 32'h100 : 32'h200);
        drive_req(0, 1'b1, 1'b1, 32'h100, 32'h1111_1111);
        drive_req(1, 1'b1, 1'b0, 32'h200, 32'h0);
        drive_resp(1'b1, 1'b0, 32'h5555_0000);
        settle();
        for (int r = 0; r < 6; r++) begin
            check("rr_idle_m_psel", 32'(m_if.psel), 32'd0);
            step();
            exp_addr = exp_q.pop_front();
            g = (exp_addr == 32'h200) ? 1 : 0;
            check("rr_setup_m_paddr", m_if.paddr, exp_addr);
            check("rr_setup_s0_pready", 32'(s0_if.pready), 32'd0);
            step();
            check("rr_access_m_paddr", m_if.paddr, exp_addr);
            check("rr_access_s0_pready", 32'(s0_if.pready), (g == 0) ? 32'd1 : 32'd0);
            check("rr_access_s1_pready", 32'(s1_if.pready), (g == 1) ? 32'd1 : 32'd0);
            check("rr_access_s0_prdata", s0_if.prdata, (g == 0) ? 32'h5555_0000 : 32'd0);
            check("rr_access_s1_prdata", s1_if.prdata, (g == 1) ? 32'h5555_0000 : 32'd0);
            step();
        end
        drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        check_quiet("rr_after");
        check("rr_queue_empty", 32'(exp_q.size()), 32'd0);

        // s1 read with three wait states and an error response
        drive_resp(1'b0, 1'b0, 32'h0);
        drive_req(1, 1'b1, 1'b0, 32'h44, 32'h0);
        settle();
        step();
        check("t3_setup_m_paddr", m_if.paddr, 32'h44);
        check("t3_setup_m_pwrite", 32'(m_if.pwrite), 32'd0);
        for (int w = 0; w < 3; w++) begin
            step();
            check("t3_wait_m_penable", 32'(m_if.penable), 32'd1);
            check("t3_wait_m_paddr",   m_if.paddr,        32'h44);
            check("t3_wait_s1_pready", 32'(s1_if.pready), 32'd0);
        end
        step();
        drive_resp(1'b1, 1'b1, 32'hDEAD_BEEF);
        settle();
        check("t3_done_m_paddr",   m_if.paddr,          32'h44);
        check("t3_done_s1_pready", 32'(s1_if.pready),   32'd1);
        check("t3_done_s1_prdata", s1_if.prdata,        32'hDEAD_BEEF);
        check("t3_done_s1_err",    32'(s1_if.pslverr),  32'd1);
        check("t3_done_s0_pready", 32'(s0_if.pready),   32'd0);
        check("t3_done_s0_prdata", s0_if.prdata,        32'd0);
        check("t3_done_s0_err",    32'(s0_if.pslverr),  32'd0);
        step();
        drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_resp(1'b0, 1'b0, 32'h0);
        settle();
        check_quiet("t3_after");

        // timeout after 4 ACCESS cycles, garbage on m.prdata must not leak
        drive_resp(1'b0, 1'b0, 32'hCAFE_F00D);
        drive_req(0, 1'b1, 1'b1, 32'h80, 32'h0BAD_0BAD);
        settle();
        step();
        for (int w = 0; w < 3; w++) begin
            step();
            check("t4_wait_s0_pready", 32'(s0_if.pready), 32'd0);
            check("t4_wait_state", 32'(dbg_state), 32'(ST_ACCESS));
        end
        step();
        check("t4_to_s0_pready", 32'(s0_if.pready),  32'd1);
        check("t4_to_s0_err",    32'(s0_if.pslverr), 32'd1);
        check("t4_to_s0_prdata", s0_if.prdata,       32'd0);
        check("t4_to_s1_pready", 32'(s1_if.pready),  32'd0);
        step();
        drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        check_quiet("t4_after");

        // reset in ACCESS, then a contested request right after release
        drive_resp(1'b0, 1'b0, 32'h0);
        drive_req(1, 1'b1, 1'b1, 32'h90, 32'h0);
        settle();
        step();
        step();
        check("t5_pre_state", 32'(dbg_state), 32'(ST_ACCESS));
        presetn = 1'b0;
        drive_req(0, 1'b1, 1'b1, 32'h30, 32'h3030_3030);
        drive_req(1, 1'b1, 1'b1, 32'h300, 32'h0);
        settle();
        step();
        check_quiet("t5_reset");
        presetn = 1'b1;
        settle();
        step();
        check("t5_setup_m_psel",  32'(m_if.psel), 32'd1);
        check("t5_setup_m_paddr", m_if.paddr,     32'h30);
        drive_resp(1'b1, 1'b0, 32'h0);
        step();
        check("t5_access_s0_pready", 32'(s0_if.pready), 32'd1);
        check("t5_access_s1_pready", 32'(s1_if.pready), 32'd0);
        step();
        drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        step();
        check("t5_s1_wait_setup_m_paddr", m_if.paddr, 32'h300);
        drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("t5_s1_wait_s1_pready", 32'(s1_if.pready), 32'd1);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
